// File: rtl/pred_ctx_seq.sv
// Context sequencer for the predicate register file: replays a configured run of
// context words onto registered control fields, optionally looping several passes.
module pred_ctx_seq #(
  parameter int CTX_DEPTH = 16,
  parameter int CTX_AW    = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cfg_we,
  input  logic [CTX_AW-1:0] cfg_addr,
  input  logic [46:0]       cfg_data,
  input  logic              start,
  input  logic              stop,
  input  logic [CTX_AW-1:0] last_ctx,
  input  logic [7:0]        iter_count,
  output logic              busy,
  output logic              done,
  output logic [CTX_AW-1:0] ctx_pc,
  output logic [8:0]        control_in_p,
  output logic [5:0]        control_put_in_p,
  output logic [5:0]        control_put_out_p,
  output logic [5:0]        control_pred,
  output logic [8:0]        control_out_p,
  output logic [5:0]        control_send_p,
  output logic [3:0]        control_pe2fu_p,
  output logic              write_back_p
);

  typedef struct packed {
    logic [8:0] in_p;
    logic [5:0] put_in_p;
    logic [5:0] put_out_p;
    logic [5:0] pred;
    logic [8:0] out_p;
    logic [5:0] send_p;
    logic [3:0] pe2fu_p;
    logic       write_back_p;
  } ctx_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Entry 63 is a scratch slot, so idle put paths point there and harmlessly
  // absorb the unconditional falling-edge writes of the predicate file.
  localparam logic [46:0]       IDLE_WORD = (47'd63 << 32) | (47'd63 << 26);
  localparam logic [CTX_AW-1:0] LAST_MAX  = CTX_AW'(CTX_DEPTH - 1);

  ctx_t [CTX_DEPTH-1:0] ctx_mem;
  ctx_t                 ctrl_q;
  logic [1:0]           state;
  logic [CTX_AW-1:0]    last_q;
  logic [7:0]           pass_q;
  logic [CTX_AW-1:0]    nxt_pc;
  logic [CTX_AW-1:0]    last_clamped;
  logic                 addr_ok;

  always_comb begin
    nxt_pc       = ctx_pc + 1'b1;
    last_clamped = ({{(32-CTX_AW){1'b0}}, last_ctx} >= 32'(CTX_DEPTH)) ? LAST_MAX : last_ctx;
    addr_ok      = ({{(32-CTX_AW){1'b0}}, cfg_addr} < 32'(CTX_DEPTH));
  end

  // Context storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (RST_N && cfg_we && addr_ok && state == IDLE)
      ctx_mem[cfg_addr] <= ctx_t'(cfg_data);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      ctx_pc <= '0;
      last_q <= '0;
      pass_q <= '0;
      done   <= 1'b0;
      ctrl_q <= ctx_t'(IDLE_WORD);
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !stop) begin
            state  <= RUN;
            last_q <= last_clamped;
            pass_q <= iter_count;
            ctx_pc <= '0;
            ctrl_q <= ctx_mem[0];
          end
        end
        RUN: begin
          // stop outranks both the wrap and the completion decisions
          if (stop) begin
            state  <= IDLE;
            ctx_pc <= '0;
            ctrl_q <= ctx_t'(IDLE_WORD);
          end else if (ctx_pc < last_q) begin
            ctx_pc <= nxt_pc;
            ctrl_q <= ctx_mem[nxt_pc];
          end else if (pass_q != 8'd0) begin
            ctx_pc <= '0;
            pass_q <= pass_q - 8'd1;
            ctrl_q <= ctx_mem[0];
          end else begin
            state  <= DONE;
            ctx_pc <= '0;
            done   <= 1'b1;
            ctrl_q <= ctx_t'(IDLE_WORD);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done   <= 1'b0;
          ctx_pc <= '0;
          ctrl_q <= ctx_t'(IDLE_WORD);
        end
      endcase
    end
  end

  assign busy              = (state == RUN);
  assign control_in_p      = ctrl_q.in_p;
  assign control_put_in_p  = ctrl_q.put_in_p;
  assign control_put_out_p = ctrl_q.put_out_p;
  assign control_pred      = ctrl_q.pred;
  assign control_out_p     = ctrl_q.out_p;
  assign control_send_p    = ctrl_q.send_p;
  assign control_pe2fu_p   = ctrl_q.pe2fu_p;
  assign write_back_p      = ctrl_q.write_back_p;

endmodule

// File: tb/tb_pred_ctx_seq.sv
// Bench for pred_ctx_seq: scenario table, hand-written corner sequences and
// randomized runs, all checked against a queue-based model of the run.
module tb_pred_ctx_seq;
  localparam int DEPTH = 12;
  localparam logic [46:0] IDLE_W = (47'd63 << 32) | (47'd63 << 26);

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [46:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  last_ctx = '0;
  logic [7:0]  iter_count = '0;
  logic        busy, done;
  logic [3:0]  ctx_pc;
  logic [8:0]  control_in_p, control_out_p;
  logic [5:0]  control_put_in_p, control_put_out_p, control_pred, control_send_p;
  logic [3:0]  control_pe2fu_p;
  logic        write_back_p;
  logic [46:0] obs;

  pred_ctx_seq #(.CTX_DEPTH(DEPTH), .CTX_AW(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .last_ctx(last_ctx), .iter_count(iter_count),
    .busy(busy), .done(done), .ctx_pc(ctx_pc),
    .control_in_p(control_in_p), .control_put_in_p(control_put_in_p),
    .control_put_out_p(control_put_out_p), .control_pred(control_pred),
    .control_out_p(control_out_p), .control_send_p(control_send_p),
    .control_pe2fu_p(control_pe2fu_p), .write_back_p(write_back_p)
  );

  always #5 CLK = ~CLK;

  assign obs = {control_in_p, control_put_in_p, control_put_out_p, control_pred,
                control_out_p, control_send_p, control_pe2fu_p, write_back_p};

  logic [46:0] mem [DEPTH];
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string name;
    int    lst;
    int    itr;
    int    stop_at;
    bit    poke;
    int    exp_busy;
  } vec_t;
  vec_t tbl [8];

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input int addr, input logic [46:0] d);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = d;
    step();
    cfg_we = 1'b0;
    mem[addr] = d;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " outs"}, obs, IDLE_W);
    chk({nm, " pc"}, ctx_pc, 0);
  endtask

  // Expected run is the flat list of context indices, one per busy cycle.
  task automatic run_check(input string nm, input int lst, input int itr,
                           input int stop_at, input bit poke, input int exp_busy);
    int q[$];
    int el, nb;
    bit aborted;
    el = (lst >= DEPTH) ? DEPTH - 1 : lst;
    for (int p = 0; p <= itr; p++)
      for (int i = 0; i <= el; i++) q.push_back(i);
    last_ctx = 4'(lst); iter_count = 8'(itr); start = 1'b1;
    step();
    start = 1'b0;
    nb = 0; aborted = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      if (busy) nb++;
      chk({nm, " run busy"}, busy, 1);
      chk({nm, " run pc"}, ctx_pc, q[k]);
      chk({nm, " run outs"}, obs, mem[q[k]]);
      chk({nm, " run done"}, done, 0);
      if (k == stop_at) stop = 1'b1;
      if (poke && k == 1) begin
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = ~mem[2];
      end
      step();
      stop = 1'b0; cfg_we = 1'b0;
      if (k == stop_at) begin aborted = 1'b1; break; end
    end
    if (aborted) begin
      chk_idle({nm, " abort"});
      step();
      chk({nm, " abort done"}, done, 0);
      chk({nm, " abort busy"}, busy, 0);
    end else begin
      chk({nm, " end done"}, done, 1);
      chk({nm, " end busy"}, busy, 0);
      chk({nm, " end outs"}, obs, IDLE_W);
      step();
      chk_idle({nm, " post"});
    end
    chk({nm, " busy cycles"}, nb, exp_busy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"basic",      3,  0, -1, 1'b0, 4};
    tbl[1] = '{"loop",       1,  2, -1, 1'b0, 6};
    tbl[2] = '{"abort",      3,  1,  2, 1'b0, 3};
    tbl[3] = '{"cfg_poke",   3,  0, -1, 1'b1, 4};
    tbl[4] = '{"guard_rerun",3,  0, -1, 1'b0, 4};
    tbl[5] = '{"single",     0,  0, -1, 1'b0, 1};
    tbl[6] = '{"clamp",      14, 0, -1, 1'b0, 12};
    tbl[7] = '{"stop_last",  1,  0,  1, 1'b0, 2};

    @(negedge CLK);
    step();
    chk_idle("reset");
    RST_N = 1'b1;
    step();
    chk_idle("after_reset");

    for (int i = 0; i < DEPTH; i++)
      cfg_write(i, 47'({$urandom(), $urandom()}) ^ 47'(i));

    // write attempted while in reset must not land
    RST_N = 1'b0; cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = ~mem[5];
    step();
    cfg_we = 1'b0; RST_N = 1'b1;
    step();

    for (int t = 0; t < 8; t++)
      run_check(tbl[t].name, tbl[t].lst, tbl[t].itr, tbl[t].stop_at, tbl[t].poke, tbl[t].exp_busy);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; last_ctx = 4'd3; iter_count = 8'd0;
    step();
    start = 1'b0; stop = 1'b0;
    chk_idle("start_stop");
    step();
    chk_idle("start_stop2");

    // reset in the middle of a run, then replay
    last_ctx = 4'd3; iter_count = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("midrst busy before", busy, 1);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    chk_idle("midrst");
    step();
    chk_idle("midrst2");
    run_check("replay", 3, 1, -1, 1'b0, 8);

    for (int r = 0; r < 25; r++) begin
      int lst, itr, el, n, sa, nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        cfg_write($urandom_range(0, DEPTH - 1), 47'({$urandom(), $urandom()}));
      lst = $urandom_range(0, 15);
      itr = $urandom_range(0, 3);
      el = (lst >= DEPTH) ? DEPTH - 1 : lst;
      n = (el + 1) * (itr + 1);
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_check("rand", lst, itr, sa, 1'b0, (sa >= 0) ? sa + 1 : n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pred_ctx_seq.md
PRED_CTX_SEQ -- requirements
Module: pred_ctx_seq

Interface
REQ-001 SHALL have parameter CTX_DEPTH, default 16, giving the number of context words.
REQ-002 SHALL have parameter CTX_AW, default 4, giving the context address width.
REQ-003 SHALL have port CLK, input, 1 bit, the single clock; all state updates occur on the rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit, reset that is synchronous and active-low.
REQ-005 SHALL have port cfg_we, input, 1 bit, context-word write enable.
REQ-006 SHALL have port cfg_addr, input, CTX_AW bits, context write address.
REQ-007 SHALL have port cfg_data, input, 47 bits, context word.
REQ-008 SHALL have port start, input, 1 bit, begin sequencing.
REQ-009 SHALL have port stop, input, 1 bit, abort sequencing.
REQ-010 SHALL have port last_ctx, input, CTX_AW bits, index of the final context per pass.
REQ-011 SHALL have port iter_count, input, 8 bits, extra passes; total passes = iter_count+1.
REQ-012 SHALL have port busy, output, 1 bit, high in RUN.
REQ-013 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-014 SHALL have port ctx_pc, output, CTX_AW bits, index of the context currently driven.
REQ-015 SHALL have ports control_in_p (9), control_put_in_p (6), control_put_out_p (6), control_pred (6), control_out_p (9), control_send_p (6), control_pe2fu_p (4) and write_back_p (1), all outputs that drive the predicate register file.

Function
REQ-016 SHALL store contexts in a CTX_DEPTH x 47 register array, written on the rising edge when cfg_we=1 and state is IDLE; writes SHALL be ignored in RUN and DONE.
REQ-017 SHALL use this context field layout: [46:38] control_in_p, [37:32] control_put_in_p, [31:26] control_put_out_p, [25:20] control_pred, [19:11] control_out_p, [10:5] control_send_p, [4:1] control_pe2fu_p, [0] write_back_p.
REQ-018 SHALL register all control outputs so they are stable before the falling edge at which the predicate file writes.
REQ-019 SHALL drive these idle control values: all fields 0 except control_put_in_p=63 and control_put_out_p=63; entry 63 is a scratch entry that absorbs unconditional falling-edge writes.
REQ-020 SHALL implement states IDLE, RUN and DONE.
REQ-021 IDLE->RUN SHALL occur on start=1 with stop=0; at that edge last_ctx and iter_count are latched, ctx_pc=0, outputs=ctx[0], and busy=1.
REQ-022 In RUN with ctx_pc<latched last_ctx, the block SHALL increment ctx_pc and load outputs from ctx[ctx_pc+1].
REQ-023 In RUN with ctx_pc==last_ctx and remaining passes>0, the block SHALL wrap ctx_pc to 0, decrement the pass counter, and load ctx[0], with no idle bubble.
REQ-024 In RUN with ctx_pc==last_ctx and remaining passes==0, the block SHALL go to DONE with idle outputs, done=1 and busy=0.
REQ-025 DONE SHALL last exactly one cycle, then go to IDLE with done=0.
REQ-026 stop=1 in RUN SHALL force IDLE at the next edge, with idle outputs, ctx_pc=0 and no done pulse.
REQ-027 stop=1 in RUN SHALL take priority over wrap and completion in the same cycle.
REQ-028 start SHALL be ignored in RUN and DONE.
REQ-029 start and stop both high in IDLE SHALL leave the block in IDLE.
REQ-030 last_ctx=0 SHALL run one context per pass.
REQ-031 last_ctx >= CTX_DEPTH SHALL be clamped to CTX_DEPTH-1.
REQ-032 Latency: first context SHALL be driven 1 cycle after start; a run SHALL be busy for exactly (last_ctx+1)*(iter_count+1) cycles.

Reset
REQ-033 When RST_N=0 at a rising edge, the block SHALL set state=IDLE, ctx_pc=0, busy=0, done=0, pass counter=0, and control outputs to idle values, overriding any run in progress.
REQ-034 Context memory SHALL NOT be reset; its contents are undefined until written.
REQ-035 cfg_we SHALL be ignored while RST_N=0.

Verification
REQ-036 The bench SHALL cover basic run: write ctx0..3 with distinct values; last_ctx=3, iter_count=0, pulse start -> outputs equal ctx0..ctx3 on 4 consecutive cycles, busy high 4 cycles, done pulse on cycle 5, then idle values (put_in/put_out=63).
REQ-037 The bench SHALL cover looping: last_ctx=1, iter_count=2 -> ctx_pc sequence 0,1,0,1,0,1 with no gap, then done.
REQ-038 The bench SHALL cover abort: stop asserted during the 3rd RUN cycle -> idle outputs next cycle, busy=0, done never asserted.
REQ-039 The bench SHALL cover the config guard: cfg_we pulse to addr 2 during RUN -> ctx2 unchanged in a following run.
REQ-040 The bench SHALL cover reset mid-run: RST_N=0 for one edge during RUN -> IDLE, idle outputs, done=0; a subsequent start replays stored contexts correctly.
REQ-041 The bench SHALL cover edge cases: last_ctx=0 with iter_count=0 -> busy one cycle; start+stop together in IDLE -> stays IDLE.
